// File: rtl/cpu_pkg.sv
// Shared encodings and width constants for the fetch path of the single-cycle CPU.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_RUN   = 2'b01,
        S_HALT  = 2'b10,
        S_FAULT = 2'b11
    } state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection plus the alignment/range fault check on the chosen target.
module next_pc_mux
    import cpu_pkg::*;
#(
    parameter int IMEM_BYTES = 128
) (
    input  logic [WORD_W-1:0] pc,
    input  logic [1:0]        pc_src,
    input  logic [WORD_W-1:0] imm,
    input  logic [25:0]       jaddr,
    input  logic [WORD_W-1:0] reg_addr,
    output logic [WORD_W-1:0] target,
    output logic              fault
);

    localparam logic [WORD_W-1:0] LIMIT = WORD_W'(IMEM_BYTES);

    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] branch_target;
    logic [WORD_W-1:0] jump_target;

    assign pc4           = pc + 32'd4;
    assign branch_target = pc4 + {imm[29:0], 2'b00};
    assign jump_target   = {pc4[31:28], jaddr, 2'b00};

    always_comb begin
        target = pc4;
        case (pcsrc_e'(pc_src))
            PCSRC_SEQ: target = pc4;
            PCSRC_BR:  target = branch_target;
            PCSRC_JR:  target = reg_addr;
            PCSRC_J:   target = jump_target;
            default:   target = pc4;
        endcase
    end

    // A wrapped PC+4 lands at 0 only from 0xFFFF_FFFC, which is already out of range.
    assign fault = (target[1:0] != 2'b00) || (target >= LIMIT);

endmodule

// File: rtl/pc_fetch.sv
// Program counter, fetch sequencing FSM and retired-fetch counter feeding instMem.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] Imm,
    input  logic [25:0] JAddr,
    input  logic [31:0] RegAddr,
    input  logic        Halt,
    output logic [31:0] IAddr,
    output logic [31:0] PC4,
    output logic        Fault,
    output logic [1:0]  State,
    output logic [31:0] InstCount
);

    state_e            state_reg, state_next;
    logic [WORD_W-1:0] pc_reg, pc_next;
    logic [WORD_W-1:0] count_reg, count_next;
    logic              fault_reg, fault_next;

    logic [WORD_W-1:0] target;
    logic              target_fault;

    next_pc_mux #(
        .IMEM_BYTES(IMEM_BYTES)
    ) u_next_pc_mux (
        .pc       (pc_reg),
        .pc_src   (PCSrc),
        .imm      (Imm),
        .jaddr    (JAddr),
        .reg_addr (RegAddr),
        .target   (target),
        .fault    (target_fault)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg <= S_INIT;
            pc_reg    <= RESET_ADDR;
            count_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
            fault_reg <= fault_next;
        end
    end

    // Priority in RUN: halt, then stall, then fault, then commit the target.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        fault_next = fault_reg;
        case (state_reg)
            S_INIT: state_next = S_RUN;
            S_RUN: begin
                if (Halt) begin
                    state_next = S_HALT;
                end else if (!PCWre) begin
                    state_next = S_RUN;
                end else if (target_fault) begin
                    state_next = S_FAULT;
                    fault_next = 1'b1;
                end else begin
                    pc_next    = target;
                    count_next = count_reg + 32'd1;
                end
            end
            S_HALT:  state_next = S_HALT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_INIT;
        endcase
    end

    assign IAddr     = pc_reg;
    assign PC4       = pc_reg + 32'd4;
    assign Fault     = fault_reg;
    assign State     = state_reg;
    assign InstCount = count_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed-vector bench for pc_fetch: sequencing, branches, jumps, stall, halt, faults and resets.
module tb_pc_fetch;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] Imm;
    logic [25:0] JAddr;
    logic [31:0] RegAddr;
    logic        Halt;
    logic [31:0] IAddr;
    logic [31:0] PC4;
    logic        Fault;
    logic [1:0]  State;
    logic [31:0] InstCount;

    int vectors    = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    pc_fetch #(
        .RESET_ADDR(32'h0000_0000),
        .IMEM_BYTES(128)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .Imm       (Imm),
        .JAddr     (JAddr),
        .RegAddr   (RegAddr),
        .Halt      (Halt),
        .IAddr     (IAddr),
        .PC4       (PC4),
        .Fault     (Fault),
        .State     (State),
        .InstCount (InstCount)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [31:0] ia, input logic [1:0] st,
                              input logic f, input logic [31:0] cnt);
        check_val({tag, ".IAddr"}, IAddr, ia);
        check_val({tag, ".PC4"}, PC4, ia + 32'd4);
        check_val({tag, ".State"}, {30'd0, State}, {30'd0, st});
        check_val({tag, ".Fault"}, {31'd0, Fault}, {31'd0, f});
        check_val({tag, ".InstCount"}, InstCount, cnt);
        $display("[%0t] %s: IAddr=%h State=%0d Fault=%0b InstCount=%0d", $time, tag, IAddr, State, Fault, InstCount);
    endtask

    // Advance one edge and sample 1 time unit afterwards.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] imm_v,
                         input logic [25:0] ja, input logic [31:0] ra, input logic h);
        PCWre = we; PCSrc = src; Imm = imm_v; JAddr = ja; RegAddr = ra; Halt = h;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        drive(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0);
        #2;

        // Reset, then sequential fetch
        do_reset();
        expect_all("reset", 32'd0, 2'b00, 1'b0, 32'd0);
        step(); expect_all("init", 32'd0, 2'b01, 1'b0, 32'd0);
        step(); expect_all("seq4", 32'd4, 2'b01, 1'b0, 32'd1);
        step(); expect_all("seq8", 32'd8, 2'b01, 1'b0, 32'd2);

        // Branches: 8 -> 12 + (-8) = 4, then 4 -> 8 + 12 = 20
        drive(1'b1, 2'b01, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0);
        step(); expect_all("br_back", 32'd4, 2'b01, 1'b0, 32'd3);
        drive(1'b1, 2'b01, 32'd3, 26'd0, 32'd0, 1'b0);
        step(); expect_all("br_fwd", 32'd20, 2'b01, 1'b0, 32'd4);

        // Jump and jump-register
        drive(1'b1, 2'b11, 32'd0, 26'd10, 32'd0, 1'b0);
        step(); expect_all("jump", 32'd40, 2'b01, 1'b0, 32'd5);
        drive(1'b1, 2'b10, 32'd0, 26'd0, 32'h1C, 1'b0);
        step(); expect_all("jr", 32'd28, 2'b01, 1'b0, 32'd6);

        // Stall with a faulting target selected: stall wins, nothing moves
        drive(1'b0, 2'b10, 32'd0, 26'd0, 32'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); expect_all($sformatf("stall%0d", i), 32'd28, 2'b01, 1'b0, 32'd6);
        end

        // Halt with a faulting target: halt wins
        drive(1'b1, 2'b10, 32'd0, 26'd0, 32'h22, 1'b1);
        step(); expect_all("halt", 32'd28, 2'b10, 1'b0, 32'd6);
        drive(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(); expect_all($sformatf("halted%0d", i), 32'd28, 2'b10, 1'b0, 32'd6);
        end

        // Reset from HALT, resume
        do_reset();
        expect_all("rst_halt", 32'd0, 2'b00, 1'b0, 32'd0);
        step(); expect_all("rst_halt_init", 32'd0, 2'b01, 1'b0, 32'd0);
        step(); expect_all("rst_halt_seq", 32'd4, 2'b01, 1'b0, 32'd1);

        // Misaligned jump-register target
        drive(1'b1, 2'b10, 32'd0, 26'd0, 32'h22, 1'b0);
        step(); expect_all("fault_align", 32'd4, 2'b11, 1'b1, 32'd1);
        drive(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); expect_all($sformatf("faulted%0d", i), 32'd4, 2'b11, 1'b1, 32'd1);
        end

        // Reset from FAULT, then range boundary: 124 legal, 124+4=128 faults
        do_reset();
        expect_all("rst_fault", 32'd0, 2'b00, 1'b0, 32'd0);
        step(); expect_all("rst_fault_init", 32'd0, 2'b01, 1'b0, 32'd0);
        drive(1'b1, 2'b10, 32'd0, 26'd0, 32'd124, 1'b0);
        step(); expect_all("jr_124", 32'd124, 2'b01, 1'b0, 32'd1);
        drive(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0);
        step(); expect_all("seq_128", 32'd124, 2'b11, 1'b1, 32'd1);

        // RegAddr = IMEM_BYTES faults directly
        do_reset();
        step(); expect_all("init3", 32'd0, 2'b01, 1'b0, 32'd0);
        drive(1'b1, 2'b10, 32'd0, 26'd0, 32'd128, 1'b0);
        step(); expect_all("jr_128", 32'd0, 2'b11, 1'b1, 32'd0);

        // Normal sequencing after a final reset
        do_reset();
        drive(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0);
        step(); expect_all("final_init", 32'd0, 2'b01, 1'b0, 32'd0);
        step(); expect_all("final_seq", 32'd4, 2'b01, 1'b0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
